// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths, flat-index helper, saturation helper and drain FSM states
package matrix_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int OUTPUT_DATA_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic {IDLE, STREAM} state_e;

    function automatic int idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    // Clamp v to w bits; widths of 64 or more pass through unchanged.
    function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int w);
        if (w >= 64) return v;
        return (v >> w) != 64'd0 ? (64'd1 << w) - 64'd1 : v;
    endfunction

endpackage

// File: rtl/matrix_result_drain_if.sv
// matrix_result_drain_if: valid/ready result stream with row/column and end markers
interface matrix_result_drain_if #(
    parameter int OUT_WIDTH = 16,
    parameter int ROW_W     = 2,
    parameter int COL_W     = 2
);
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ROW_W-1:0]     out_row;
    logic [COL_W-1:0]     out_col;
    logic                 out_last_col;
    logic                 out_last;

    modport master (
        output out_data, out_valid, out_row, out_col, out_last_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_row, out_col, out_last_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_sat.sv
// matrix_sat: combinational unsigned saturator narrowing IN_W to OUT_W bits
module matrix_sat #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);
    generate
        if (OUT_W == IN_W) begin : g_pass
            assign out_o = in_i;
        end else begin : g_sat
            assign out_o = |in_i[IN_W-1:OUT_W] ? '1 : in_i[OUT_W-1:0];
        end
    endgenerate
endmodule

// File: rtl/matrix_result_drain.sv
// matrix_result_drain: snapshots the multiplier result on res_done and streams it
// row-major, one element per accepted beat, with optional unsigned saturation.
module matrix_result_drain
    import matrix_pkg::*;
#(
    parameter int ROWS         = 3,
    parameter int COLS         = 3,
    parameter int RESULT_WIDTH = OUTPUT_DATA_WIDTH,
    parameter int OUT_WIDTH    = OUTPUT_DATA_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ROWS*COLS*RESULT_WIDTH-1:0] res_flat,
    input  logic                              res_done,
    matrix_result_drain_if.master             out,
    output logic                              busy,
    output logic                              overrun
);
    localparam int ROW_W = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int COL_W = COLS > 1 ? $clog2(COLS) : 1;

    state_e                            state_q, state_d;
    logic [ROW_W-1:0]                  row_q, row_d;
    logic [COL_W-1:0]                  col_q, col_d;
    logic [ROWS*COLS*RESULT_WIDTH-1:0] snap_q, snap_d;
    logic                              overrun_q, overrun_d;
    logic [RESULT_WIDTH-1:0]           elem;
    logic [OUT_WIDTH-1:0]              elem_sat;
    logic                              valid, accept, at_last_col, at_last;

    assign valid       = state_q == STREAM;
    assign accept      = valid && out.out_ready;
    assign at_last_col = col_q == COL_W'(COLS - 1);
    assign at_last     = at_last_col && row_q == ROW_W'(ROWS - 1);

    always_comb begin
        elem = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (row_q == ROW_W'(r) && col_q == COL_W'(c))
                    elem = snap_q[idx(r, c, COLS)*RESULT_WIDTH +: RESULT_WIDTH];
    end

    matrix_sat #(.IN_W(RESULT_WIDTH), .OUT_W(OUT_WIDTH)) u_sat (
        .in_i  (elem),
        .out_o (elem_sat)
    );

    // Indices return to (0,0) at frame end so the idle mux never points past the snapshot.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        if (state_q == IDLE) begin
            if (res_done) begin
                state_d = STREAM;
                snap_d  = res_flat;
                row_d   = '0;
                col_d   = '0;
            end
        end else if (accept && at_last) begin
            row_d = '0;
            col_d = '0;
            if (res_done) snap_d = res_flat;
            else state_d = IDLE;
        end else begin
            if (accept) begin
                col_d = at_last_col ? '0 : col_q + 1'b1;
                row_d = at_last_col ? row_q + 1'b1 : row_q;
            end
            if (res_done) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
        end
    end

    assign out.out_valid    = valid;
    assign out.out_data     = valid ? elem_sat : '0;
    assign out.out_row      = row_q;
    assign out.out_col      = col_q;
    assign out.out_last_col = valid && at_last_col;
    assign out.out_last     = valid && at_last;
    assign busy             = valid;
    assign overrun          = overrun_q;
endmodule

// File: doc/matrix_result_drain.md
Name: matrix_result_drain

Overview:
Downstream stage of the blocked matrix multiplier. It snapshots the multiplier's flat packed result vector on its one-cycle done pulse, then streams the elements out one per accepted beat, row-major, on a valid/ready interface. Each beat carries row/column indices and end-of-row/end-of-frame markers. Optional unsigned saturation narrows elements to the output bus width.

Parameters:
ROWS, 3, result matrix row count (first-matrix row size)
COLS, 3, result matrix column count (second-matrix column size)
RESULT_WIDTH, 16, width of each packed result element (2x multiplier data width)
OUT_WIDTH, 16, streamed element width; must be <= RESULT_WIDTH
ROW_W, max(1,$clog2(ROWS)), derived localparam, row index width
COL_W, max(1,$clog2(COLS)), derived localparam, column index width

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
res_flat  input  ROWS*COLS*RESULT_WIDTH  packed results; element (r,c) at [(r*COLS+c)*RESULT_WIDTH +: RESULT_WIDTH]
res_done  input  1  one-cycle pulse; res_flat is valid in this cycle
out_data  output  OUT_WIDTH  current element, saturated
out_valid  output  1  beat valid
out_ready  input  1  consumer accepts beat when out_valid & out_ready
out_row  output  ROW_W  row index of current beat
out_col  output  COL_W  column index of current beat
out_last_col  output  1  high when out_col == COLS-1
out_last  output  1  high on final element (ROWS-1, COLS-1)
busy  output  1  frame held or streaming
overrun  output  1  sticky; a res_done was dropped

Behaviour:
- Reset: state IDLE, snapshot cleared to 0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last_col=0, out_last=0, busy=0, overrun=0. Reset mid-frame abandons the frame immediately, with no further beats.
- States: IDLE and STREAM.
- IDLE + res_done: capture res_flat into the snapshot and clear row/col to 0. Next cycle enter STREAM with out_valid=1 (capture-to-first-beat latency is 1 cycle).
- STREAM: out_valid=1 continuously.
  - out_data, out_row, out_col, out_last_col and out_last are stable while out_valid & !out_ready.
  - On accept: col increments; at col==COLS-1, col wraps to 0 and row increments.
  - Accept with out_last=1 completes the frame.
- Frame completion with no coincident res_done: return to IDLE, out_valid=0 next cycle.
- Frame completion with coincident res_done: capture the new frame and stay in STREAM with row/col=0. No bubble; the next beat is element (0,0) of the new frame.
- res_done in STREAM other than the completing accept: the pulse is dropped, overrun sets to 1 and stays until reset, and the current frame continues unaffected.
- busy = (state==STREAM).
- Saturation: if element > 2^OUT_WIDTH-1, out_data = all ones; otherwise out_data = low OUT_WIDTH bits. When OUT_WIDTH==RESULT_WIDTH this is a pass-through.
- Element selection is a combinational mux from the snapshot using the row/col registers. No skid buffer is used, so out_ready has a combinational path only into next-state logic.
- Degenerate ROWS=1 or COLS=1 must work: index widths are 1, and out_last_col / out_last behave accordingly.
- Throughput: one element per cycle with out_ready held high. A frame takes ROWS*COLS cycles plus 1 cycle of capture latency.

Decomposition:
- Shared package matrix_pkg holds:
  - widths (DATA_WIDTH, OUTPUT_DATA_WIDTH)
  - the flat-index function idx(r,c,COLS)
  - a sat_unsigned function
  - the state enum {IDLE, STREAM}
- One sub-module is natural: matrix_sat (combinational unsigned saturator, RESULT_WIDTH -> OUT_WIDTH), reused by the future signed/narrowing variants.
- The row/col counter stays inline.

Test Plan:
1. Basic frame: ROWS=COLS=3, elements (r,c)=10*r+c, res_done pulse, out_ready=1.
   -> 9 beats on consecutive cycles starting 1 cycle after res_done.
   -> Data 0,1,2,10,11,12,20,21,22; out_last_col on beats 3,6,9; out_last only on beat 9; busy drops the cycle after beat 9.
2. Backpressure: same frame, out_ready toggles 1,0,0,1,...
   -> Each beat is held stable across the stall cycles.
   -> Sequence unchanged; no element is duplicated or skipped.
3. Saturation: RESULT_WIDTH=16, OUT_WIDTH=8, elements 0x00FF, 0x0100 and 0xFFFF.
   -> out_data = 0xFF, 0xFF, 0xFF.
   -> Element 0x007F -> 0x7F.
4. Overrun: second res_done (new values) at beat 4 of a stalled frame.
   -> overrun=1 and stays high.
   -> Remaining beats come from the first frame; after completion the block returns to IDLE.
5. Back-to-back: second res_done in the same cycle as the out_last accept.
   -> The next cycle emits (0,0) of the second frame with no bubble; overrun stays 0.
6. Reset mid-frame: assert reset during beat 5.
   -> All outputs go to 0 asynchronously.
   -> After release, no beats appear until a new res_done; the new frame starts at (0,0).
